ddr3_wr_arbiter: RTL and testbench
==================================

Name: ddr3_wr_arbiter

Overview:
- Round-robin scheduler that shares the single PL-to-DDR3 S2MM write engine between two requesters, e.g. two sensor or frame channels.
- Accepts per-channel transfer descriptors (address, byte length) and validates them.
- Drives the engine's start, address and length inputs with the timing the engine needs.
- Observes the engine's AXI-Stream output to detect completion, and reports ack, done and error per channel.

Parameters:
- N_REQ, 2, number of requesters. Fixed at 2; other values are unsupported.
- TIMEOUT_CYC, 32'd1_000_000, maximum clocks allowed from start to the final beat before the arbiter declares a timeout.
- START_HI, 2, clocks that pl_ddr_wr_start is held high. Minimum 2.
- GAP_LO, 2, minimum clocks pl_ddr_wr_start is held low between transfers. Minimum 2.

Ports:
- clk  in  1  system clock, shared with the write engine
- rst_n  in  1  asynchronous active-low reset
- ddr3_init_complet  in  1  DDR3 calibration done; level signal
- req_valid  in  2  per-channel request level; held until req_ack
- req_addr  in  64  {ch1[31:0], ch0[31:0]} DDR byte address
- req_length  in  64  {ch1, ch0} transfer bytes
- req_ack  out  1 per channel (2)  one-clock pulse when the descriptor is accepted or rejected
- req_done  out  2  one-clock pulse when the channel's transfer completes
- req_err  out  2  one-clock pulse on a rejected descriptor; sticky level after a timeout
- wr_sel  out  2  one-hot owner of the engine; drives the upstream data mux
- busy  out  1  high in every state except IDLE
- pl_ddr_wr_start  out  1  engine start; the engine detects its rising edge
- pl_ddr_wr_addr  out  32  engine address
- pl_ddr_wr_length  out  32  engine byte count
- s2mm_tvalid_mon  in  1  engine s_axis_s2mm_tvalid
- s2mm_tready_mon  in  1  engine s_axis_s2mm_tready
- s2mm_tlast_mon  in  1  engine s_axis_s2mm_tlast

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs are 0.
  - state=INIT, last_grant=1, so ch0 wins the first tie.
  - Timers are cleared.
- All outputs are registered. Reset mid-transfer aborts immediately; the engine must be reset by the same reset tree.
- States and transitions:
  - INIT: wait for ddr3_init_complet=1, then go to IDLE. If ddr3_init_complet falls in any later state, no new grant is issued; a transfer already in progress completes.
  - IDLE: if any req_valid is set, go to ARB.
  - ARB (1 clk): grant the requesting channel when only one requests; if both request, grant the channel != last_grant. Update last_grant. Validate the granted length L:
    - L != 0
    - L[1:0] == 0
    - L[31:23] == 0
    If L is invalid: pulse req_ack and req_err for the granted channel and return to IDLE; no engine activity.
  - LOAD (1 clk): register pl_ddr_wr_addr and pl_ddr_wr_length, set wr_sel one-hot, pulse req_ack. Address and length stay constant until the next LOAD.
  - START: pl_ddr_wr_start=1 for START_HI clocks; the timeout counter starts at LOAD.
  - RUN: pl_ddr_wr_start=0. Wait for a beat with s2mm_tvalid_mon & s2mm_tready_mon & s2mm_tlast_mon, then pulse req_done for the owner and go to GAP.
  - GAP: hold GAP_LO clocks with start low and wr_sel cleared, then go to IDLE. A new ARB decision is taken only after GAP.
  - HALT: entered when the timeout counter reaches TIMEOUT_CYC in START or RUN. req_err[owner] stays high and busy=1. Exit only via reset, because the engine cannot be aborted.
- Completion boundaries:
  - A tlast beat arriving during START (a degenerate 4-byte transfer) counts as completion.
  - tlast with tvalid=0 is ignored.
- Request handling:
  - A req_valid deasserted before ack is simply dropped.
  - A req_valid held high after ack is a new request, eligible at the next ARB.
- Timing:
  - Best-case latency from req_valid (IDLE) to the start rising edge is 3 clocks (IDLE→ARB→LOAD→START).
  - Minimum period between back-to-back transfers is START_HI + GAP_LO + 3 clocks, plus data time.
- Widths:
  - Timeout counter is 32 bits, saturating.
  - Length is passed through unmodified; the engine itself consumes L[22:0].

Decomposition:
- Shared package ddr3_ctrl_pkg holds:
  - the state enum: INIT, IDLE, ARB, LOAD, START, RUN, GAP, HALT
  - MAX_BTT = 23'h7F_FFFC
  - S2MM_CMD_W = 72
- One sub-module, rr_arb2: a combinational 2-way round-robin pick from req and last_grant, producing a one-hot grant.

Test Plan:
- Wait for init, ch0 length=320 at addr 0x1000_0000, engine model emits 80 beats → start rises 3 clks after req, start high 2 clks, addr/len stable, req_done[0] pulses on beat 80.
- req_valid=2'b11 held through 4 transfers → grant order ch0, ch1, ch0, ch1; wr_sel matches each; start-low gap ≥2 clks between transfers.
- ch1 length=322 (not word aligned), then length=0, then length=0x0080_0000 → each produces req_ack[1]+req_err[1] together, pl_ddr_wr_start stays 0.
- ddr3_init_complet=0 with req_valid=01 → no ack for 1000 clks; raise init → transfer proceeds normally.
- TIMEOUT_CYC=100 and no tlast → req_err[0] rises at LOAD+100 and stays high, busy=1, further requests ignored until rst_n pulse; after reset all outputs are 0.
- rst_n asserted mid-RUN (beat 40 of 80) → outputs 0 in the same cycle (async); after release, INIT→IDLE and a fresh ch0 transfer completes.

Source files
------------

// File: rtl/ddr3_ctrl_pkg.sv
// ddr3_ctrl_pkg: shared types and constants for the PL-to-DDR3 write path.
//   arb_state_e : scheduler FSM states
//   wr_desc_t   : one transfer descriptor (DDR byte address, byte length)
//   MAX_BTT     : largest byte count the S2MM engine accepts (word aligned)
//   S2MM_CMD_W  : width of the engine's S2MM command word
//   len_ok()    : descriptor length check used by the arbiter
package ddr3_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT, IDLE, ARB, LOAD, START, RUN, GAP, HALT
    } arb_state_e;

    localparam logic [22:0] MAX_BTT    = 23'h7F_FFFC;
    localparam int          S2MM_CMD_W = 72;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] length;
    } wr_desc_t;

    // Non-zero, no bits above the engine's 23-bit BTT field, and no bits
    // outside MAX_BTT's mask (whose low two zeros enforce word alignment).
    function automatic logic len_ok(input logic [31:0] len);
        return (len != 32'd0) && (len[31:23] == 9'd0) &&
               ((len[22:0] & ~MAX_BTT) == 23'd0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick.
//   req        : request vector, one bit per channel
//   last_grant : index of the channel granted last time (1 -> ch0 wins a tie)
//   grant      : one-hot grant, zero when nothing requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ddr3_wr_arbiter.sv
// ddr3_wr_arbiter: shares one S2MM write engine between two requesters.
//   clk, rst_n          : clock (shared with engine), async active-low reset
//   ddr3_init_complet   : DDR3 calibration done; gates new grants
//   req_valid/addr/length : per-channel descriptors, {ch1, ch0} packed
//   req_ack/done/err    : per-channel status pulses (err sticky on timeout)
//   wr_sel              : one-hot engine owner for the upstream data mux
//   busy                : high whenever the FSM is not in IDLE
//   pl_ddr_wr_start/addr/length : engine command inputs
//   s2mm_*_mon          : engine's AXI-Stream handshake, watched for tlast
// All outputs are registered: the comb block computes next values, the
// sequential block captures them.
module ddr3_wr_arbiter
    import ddr3_ctrl_pkg::*;
#(
    parameter int          N_REQ       = 2,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000,
    parameter int          START_HI    = 2,
    parameter int          GAP_LO      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ddr3_init_complet,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_addr,
    input  logic [32*N_REQ-1:0]   req_length,
    output logic [N_REQ-1:0]      req_ack,
    output logic [N_REQ-1:0]      req_done,
    output logic [N_REQ-1:0]      req_err,
    output logic [N_REQ-1:0]      wr_sel,
    output logic                  busy,
    output logic                  pl_ddr_wr_start,
    output logic [31:0]           pl_ddr_wr_addr,
    output logic [31:0]           pl_ddr_wr_length,
    input  logic                  s2mm_tvalid_mon,
    input  logic                  s2mm_tready_mon,
    input  logic                  s2mm_tlast_mon
);

    localparam logic [7:0] START_LAST = 8'(START_HI - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_LO - 1);

    arb_state_e       state, state_nxt;
    logic             last_grant, last_nxt;
    logic [1:0]       grant;
    logic [7:0]       ph_cnt, ph_nxt;
    logic [31:0]      tmr, tmr_nxt, tmr_inc;
    logic [1:0]       ack_nxt, done_nxt, err_nxt, sel_nxt;
    logic             start_nxt, beat, timed_out;
    logic [31:0]      addr_nxt, len_nxt;
    wr_desc_t         desc [2];
    wr_desc_t         gdesc;

    // Requests are masked while calibration is down so no new grant issues.
    rr_arb2 u_rr (
        .req        (req_valid & {N_REQ{ddr3_init_complet}}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            desc[i].addr   = req_addr[32*i +: 32];
            desc[i].length = req_length[32*i +: 32];
        end
        gdesc = grant[1] ? desc[1] : desc[0];
    end

    assign beat      = s2mm_tvalid_mon & s2mm_tready_mon & s2mm_tlast_mon;
    assign tmr_inc   = (&tmr) ? tmr : tmr + 32'd1;   // saturating
    assign timed_out = (tmr_inc >= TIMEOUT_CYC);

    always_comb begin
        state_nxt = state;
        last_nxt  = last_grant;
        ph_nxt    = ph_cnt + 8'd1;
        tmr_nxt   = tmr;
        ack_nxt   = 2'b00;
        done_nxt  = 2'b00;
        err_nxt   = 2'b00;
        sel_nxt   = wr_sel;
        start_nxt = 1'b0;
        addr_nxt  = pl_ddr_wr_addr;
        len_nxt   = pl_ddr_wr_length;
        case (state)
            INIT: if (ddr3_init_complet) state_nxt = IDLE;
            IDLE: if (ddr3_init_complet && (|req_valid)) state_nxt = ARB;
            ARB: begin
                // A request dropped before this cycle simply falls back to IDLE.
                state_nxt = IDLE;
                if (|grant) begin
                    last_nxt = grant[1];
                    ack_nxt  = grant;
                    if (!len_ok(gdesc.length)) begin
                        err_nxt = grant;
                    end else begin
                        state_nxt = LOAD;
                        addr_nxt  = gdesc.addr;
                        len_nxt   = gdesc.length;
                        sel_nxt   = grant;
                        tmr_nxt   = 32'd0;
                    end
                end
            end
            LOAD: begin
                state_nxt = START;
                start_nxt = 1'b1;
                ph_nxt    = 8'd0;
                tmr_nxt   = tmr_inc;
            end
            START, RUN: begin
                tmr_nxt = tmr_inc;
                // Completion wins over timeout; a tlast beat in START is a
                // finished minimum-size transfer.
                if (beat) begin
                    state_nxt = GAP;
                    done_nxt  = wr_sel;
                    sel_nxt   = 2'b00;
                    ph_nxt    = 8'd0;
                end else if (timed_out) begin
                    state_nxt = HALT;
                    err_nxt   = wr_sel;
                end else if (state == START) begin
                    if (ph_cnt == START_LAST) state_nxt = RUN;
                    else                      start_nxt = 1'b1;
                end
            end
            GAP:  if (ph_cnt == GAP_LAST) state_nxt = IDLE;
            // Engine cannot be aborted: owner stays selected, error held.
            HALT: err_nxt = wr_sel;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= INIT;
            last_grant       <= 1'b1;
            ph_cnt           <= 8'd0;
            tmr              <= 32'd0;
            req_ack          <= '0;
            req_done         <= '0;
            req_err          <= '0;
            wr_sel           <= '0;
            busy             <= 1'b0;
            pl_ddr_wr_start  <= 1'b0;
            pl_ddr_wr_addr   <= 32'd0;
            pl_ddr_wr_length <= 32'd0;
        end else begin
            state            <= state_nxt;
            last_grant       <= last_nxt;
            ph_cnt           <= ph_nxt;
            tmr              <= tmr_nxt;
            req_ack          <= ack_nxt;
            req_done         <= done_nxt;
            req_err          <= err_nxt;
            wr_sel           <= sel_nxt;
            busy             <= (state_nxt != IDLE);
            pl_ddr_wr_start  <= start_nxt;
            pl_ddr_wr_addr   <= addr_nxt;
            pl_ddr_wr_length <= len_nxt;
        end
    end

endmodule

// File: tb/tb_ddr3_wr_arbiter.sv
// Directed bench for ddr3_wr_arbiter with a small S2MM engine model.
module tb_ddr3_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ddr3_init_complet;
    logic [1:0]  req_valid;
    logic [63:0] req_addr, req_length;
    logic [1:0]  req_ack, req_done, req_err, wr_sel;
    logic        busy, pl_ddr_wr_start;
    logic [31:0] pl_ddr_wr_addr, pl_ddr_wr_length;
    logic        s2mm_tvalid_mon, s2mm_tready_mon, s2mm_tlast_mon;

    // engine model state
    logic m_tvalid, m_tlast, start_q, inj_tlast, eng_en, eng_fast;
    int   beats_left;

    int n_tests = 0;
    int n_fail  = 0;

    wire [73:0] all_out = {req_ack, req_done, req_err, wr_sel, busy,
                           pl_ddr_wr_start, pl_ddr_wr_addr, pl_ddr_wr_length};

    assign s2mm_tvalid_mon = m_tvalid;
    assign s2mm_tready_mon = 1'b1;
    assign s2mm_tlast_mon  = m_tlast | inj_tlast;

    always #5 clk = ~clk;

    ddr3_wr_arbiter #(.TIMEOUT_CYC(32'd100)) dut (
        .clk(clk), .rst_n(rst_n), .ddr3_init_complet(ddr3_init_complet),
        .req_valid(req_valid), .req_addr(req_addr), .req_length(req_length),
        .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
        .wr_sel(wr_sel), .busy(busy), .pl_ddr_wr_start(pl_ddr_wr_start),
        .pl_ddr_wr_addr(pl_ddr_wr_addr), .pl_ddr_wr_length(pl_ddr_wr_length),
        .s2mm_tvalid_mon(s2mm_tvalid_mon), .s2mm_tready_mon(s2mm_tready_mon),
        .s2mm_tlast_mon(s2mm_tlast_mon)
    );

    // Engine: on a start rising edge, emit length/4 beats, one per clock.
    // eng_fast emits the first beat on the edge that sees start rise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0; m_tvalid <= 1'b0; m_tlast <= 1'b0; beats_left <= 0;
        end else begin
            start_q <= pl_ddr_wr_start;
            if (pl_ddr_wr_start && !start_q && eng_en) begin
                if (eng_fast) begin
                    m_tvalid   <= 1'b1;
                    m_tlast    <= (pl_ddr_wr_length[31:2] == 30'd1);
                    beats_left <= int'(pl_ddr_wr_length[31:2]) - 1;
                end else begin
                    m_tvalid   <= 1'b0;
                    m_tlast    <= 1'b0;
                    beats_left <= int'(pl_ddr_wr_length[31:2]);
                end
            end else if (beats_left > 0) begin
                m_tvalid   <= 1'b1;
                m_tlast    <= (beats_left == 1);
                beats_left <= beats_left - 1;
            end else begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 2'b00; inj_tlast = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Request on channel mask ch, drop it at ack, return ack/done info.
    task automatic run_xfer(input logic [1:0] ch, input int bound,
                            output int ack_c, output logic [1:0] ack_v,
                            output int done_c, output logic [1:0] done_v);
        ack_c = -1; done_c = -1; ack_v = 2'b00; done_v = 2'b00;
        req_valid = ch;
        for (int c = 1; c <= bound; c++) begin
            @(posedge clk); #1;
            if (req_ack != 2'b00 && ack_c < 0) begin
                ack_c = c; ack_v = req_ack; req_valid = 2'b00;
            end
            if (req_done != 2'b00 && done_c < 0) begin
                done_c = c; done_v = req_done;
            end
            if (done_c >= 0 && c == done_c + 3) break;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (all_out !== 74'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 ddr3_init_complet = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (all_out !== 74'd0) begin
            n_fail++; $display("FAIL idle_outputs: got %h want 0", all_out);
        end
    endtask

    task automatic test_single();
        int ack_c = -1, start_c = -1, hi_cnt = 0, done_c = -1;
        int done_beats = -1, beats = 0, unstable = 0;
        logic [1:0] ack_v = 2'b00, err_v = 2'b11, sel_v = 2'b00;
        logic [1:0] done_v = 2'b00, done_after = 2'b11, sel_end = 2'b11;
        logic busy_end = 1'b1;
        req_addr[31:0] = 32'h1000_0000; req_length[31:0] = 32'd320;
        req_valid = 2'b01;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (req_ack != 2'b00 && ack_c < 0) begin
                ack_c = c; ack_v = req_ack; err_v = req_err; sel_v = wr_sel;
                req_valid = 2'b00;
            end
            if (ack_c >= 0 && (pl_ddr_wr_addr !== 32'h1000_0000 ||
                               pl_ddr_wr_length !== 32'd320)) unstable++;
            if (pl_ddr_wr_start) begin
                hi_cnt++;
                if (start_c < 0) start_c = c;
            end
            if (done_c >= 0 && c == done_c + 1) done_after = req_done;
            if (req_done != 2'b00 && done_c < 0) begin
                done_c = c; done_v = req_done; done_beats = beats;
            end
            if (s2mm_tvalid_mon && s2mm_tready_mon) beats++;
            if (done_c >= 0 && c == done_c + 4) begin
                busy_end = busy; sel_end = wr_sel; break;
            end
        end
        req_valid = 2'b00;
        n_tests++; if (ack_c !== 2) begin n_fail++; $display("FAIL single_ack_cycle: got %0d want 2", ack_c); end
        n_tests++; if (ack_v !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b want 01", ack_v); end
        n_tests++; if (err_v !== 2'b00) begin n_fail++; $display("FAIL single_err: got %b want 00", err_v); end
        n_tests++; if (sel_v !== 2'b01) begin n_fail++; $display("FAIL single_wr_sel: got %b want 01", sel_v); end
        n_tests++; if (start_c !== 3) begin n_fail++; $display("FAIL single_start_latency: got %0d want 3", start_c); end
        n_tests++; if (hi_cnt !== 2) begin n_fail++; $display("FAIL single_start_width: got %0d want 2", hi_cnt); end
        n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL single_addr_len_stable: got %0d bad cycles want 0", unstable); end
        n_tests++; if (done_v !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b want 01", done_v); end
        n_tests++; if (done_beats !== 80) begin n_fail++; $display("FAIL single_done_beat: got %0d want 80", done_beats); end
        n_tests++; if (done_after !== 2'b00) begin n_fail++; $display("FAIL single_done_pulse: got %b want 00", done_after); end
        n_tests++; if (busy_end !== 1'b0 || sel_end !== 2'b00) begin
            n_fail++; $display("FAIL single_idle_after: got busy=%b sel=%b want 0/00", busy_end, sel_end);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] acks [4];
        logic [1:0] sels [4];
        logic [1:0] dones [4];
        logic [1:0] exp;
        int na = 0, nd = 0, min_gap = 1000, low = 0, extra = 0;
        logic seen_fall = 1'b0, prev = 1'b0;
        do_reset();
        req_addr = {32'h2000_0000, 32'h1000_0000};
        req_length = {32'd16, 32'd16};
        req_valid = 2'b11;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk); #1;
            if (req_ack != 2'b00 && na < 4) begin acks[na] = req_ack; sels[na] = wr_sel; na++; end
            if (req_done != 2'b00 && nd < 4) begin
                dones[nd] = req_done; nd++;
                if (nd == 4) req_valid = 2'b00;
            end
            if (pl_ddr_wr_start) begin
                if (!prev && seen_fall && low < min_gap) min_gap = low;
                low = 0;
            end else begin
                low++;
                if (prev) seen_fall = 1'b1;
            end
            prev = pl_ddr_wr_start;
            if (nd == 4) break;
        end
        req_valid = 2'b00;
        repeat (10) begin
            @(posedge clk); #1;
            if (req_ack != 2'b00) extra++;
        end
        n_tests++; if (na !== 4 || nd !== 4) begin n_fail++; $display("FAIL rr_count: got acks=%0d dones=%0d want 4/4", na, nd); end
        for (int i = 0; i < na && i < nd; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++; if (acks[i] !== exp) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", i, acks[i], exp); end
            n_tests++; if (sels[i] !== exp) begin n_fail++; $display("FAIL rr_wr_sel%0d: got %b want %b", i, sels[i], exp); end
            n_tests++; if (dones[i] !== exp) begin n_fail++; $display("FAIL rr_done%0d: got %b want %b", i, dones[i], exp); end
        end
        n_tests++; if (!(min_gap >= 2 && min_gap < 1000)) begin n_fail++; $display("FAIL rr_start_gap: got %0d want >=2", min_gap); end
        n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL rr_no_extra_ack: got %0d want 0", extra); end
    endtask

    task automatic test_bad_len();
        logic [31:0] bad [3];
        bad[0] = 32'd322; bad[1] = 32'd0; bad[2] = 32'h0080_0000;
        for (int i = 0; i < 3; i++) begin
            int ack_c = -1;
            logic [1:0] ack_v = 2'b00, err_v = 2'b00, err_after = 2'b11;
            logic start_seen = 1'b0;
            req_length[63:32] = bad[i];
            req_valid = 2'b10;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (pl_ddr_wr_start) start_seen = 1'b1;
                if (ack_c >= 0 && c == ack_c + 1) err_after = req_err;
                if (req_ack != 2'b00 && ack_c < 0) begin
                    ack_c = c; ack_v = req_ack; err_v = req_err; req_valid = 2'b00;
                end
            end
            req_valid = 2'b00;
            n_tests++; if (ack_v !== 2'b10) begin n_fail++; $display("FAIL badlen%0d_ack: got %b want 10", i, ack_v); end
            n_tests++; if (err_v !== 2'b10) begin n_fail++; $display("FAIL badlen%0d_err: got %b want 10", i, err_v); end
            n_tests++; if (err_after !== 2'b00) begin n_fail++; $display("FAIL badlen%0d_err_pulse: got %b want 00", i, err_after); end
            n_tests++; if (start_seen !== 1'b0) begin n_fail++; $display("FAIL badlen%0d_no_start: got %b want 0", i, start_seen); end
        end
    endtask

    task automatic test_start_tlast();
        int ack_c, done_c;
        logic [1:0] ack_v, done_v;
        eng_fast = 1'b1;
        req_addr[31:0] = 32'h1000_4000; req_length[31:0] = 32'd4;
        run_xfer(2'b01, 100, ack_c, ack_v, done_c, done_v);
        eng_fast = 1'b0;
        n_tests++; if (done_v !== 2'b01 || done_c !== 5) begin
            n_fail++; $display("FAIL start_tlast_done: got %b at %0d want 01 at 5", done_v, done_c);
        end
    endtask

    task automatic test_init_gate();
        int ack_c, done_c, early = 0;
        logic [1:0] ack_v, done_v;
        ddr3_init_complet = 1'b0;
        req_length[31:0] = 32'd16;
        req_valid = 2'b01;
        repeat (1000) begin
            @(posedge clk); #1;
            if (req_ack != 2'b00) early++;
        end
        ddr3_init_complet = 1'b1;
        run_xfer(2'b01, 100, ack_c, ack_v, done_c, done_v);
        n_tests++; if (early !== 0) begin n_fail++; $display("FAIL init_gate_no_ack: got %0d acks want 0", early); end
        n_tests++; if (ack_v !== 2'b01 || done_v !== 2'b01) begin
            n_fail++; $display("FAIL init_gate_resume: got ack=%b done=%b want 01/01", ack_v, done_v);
        end
    endtask

    task automatic test_timeout();
        int ack_c = -1, err_c = -1, lost = 0, acks = 0, starts = 0;
        logic [1:0] err_v = 2'b00;
        logic done_seen = 1'b0;
        do_reset();
        eng_en = 1'b0;
        req_length[31:0] = 32'd16;
        req_valid = 2'b01;
        for (int c = 1; c <= 250; c++) begin
            @(posedge clk); #1;
            if (req_done != 2'b00) done_seen = 1'b1;
            if (req_ack != 2'b00 && ack_c < 0) begin ack_c = c; req_valid = 2'b00; end
            if (req_err != 2'b00 && err_c < 0) begin err_c = c; err_v = req_err; end
            if (err_c >= 0 && (req_err !== 2'b01 || busy !== 1'b1)) lost++;
            // lone tlast with tvalid low must not complete the transfer
            inj_tlast = (ack_c >= 0 && c == ack_c + 10);
            if (err_c >= 0 && c == err_c + 50) break;
        end
        inj_tlast = 1'b0;
        req_valid = 2'b10;
        repeat (30) begin
            @(posedge clk); #1;
            if (req_ack != 2'b00) acks++;
            if (pl_ddr_wr_start) starts++;
            if (req_err !== 2'b01 || busy !== 1'b1) lost++;
        end
        req_valid = 2'b00;
        n_tests++; if (err_c - ack_c !== 100 || ack_c < 0) begin
            n_fail++; $display("FAIL timeout_cycle: got %0d want 100", err_c - ack_c);
        end
        n_tests++; if (err_v !== 2'b01) begin n_fail++; $display("FAIL timeout_err: got %b want 01", err_v); end
        n_tests++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL timeout_no_done: got %b want 0", done_seen); end
        n_tests++; if (lost !== 0) begin n_fail++; $display("FAIL timeout_sticky: got %0d bad cycles want 0", lost); end
        n_tests++; if (acks !== 0 || starts !== 0) begin
            n_fail++; $display("FAIL timeout_ignore_req: got acks=%0d starts=%0d want 0/0", acks, starts);
        end
        rst_n = 1'b0;
        #1;
        n_tests++; if (all_out !== 74'd0) begin n_fail++; $display("FAIL timeout_reset_outputs: got %h want 0", all_out); end
        eng_en = 1'b1;
        do_reset();
    endtask

    task automatic test_reset_mid_run();
        int beats = 0, ack_c, done_c;
        logic [1:0] ack_v, done_v;
        logic hit = 1'b0;
        req_addr[31:0] = 32'h1000_0000; req_length[31:0] = 32'd320;
        req_valid = 2'b01;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (req_ack != 2'b00) req_valid = 2'b00;
            if (s2mm_tvalid_mon && s2mm_tready_mon) beats++;
            if (beats == 40) begin hit = 1'b1; break; end
        end
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL midrun_reach_beat40: got %b want 1", hit); end
        n_tests++; if (all_out !== 74'd0) begin n_fail++; $display("FAIL midrun_async_reset: got %h want 0", all_out); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_length[31:0] = 32'd16;
        run_xfer(2'b01, 100, ack_c, ack_v, done_c, done_v);
        n_tests++; if (ack_v !== 2'b01 || done_v !== 2'b01) begin
            n_fail++; $display("FAIL midrun_fresh_xfer: got ack=%b done=%b want 01/01", ack_v, done_v);
        end
    endtask

    initial begin
        ddr3_init_complet = 1'b0;
        req_valid = 2'b00; req_addr = 64'd0; req_length = 64'd0;
        inj_tlast = 1'b0; eng_en = 1'b1; eng_fast = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_len();
        test_start_tlast();
        test_init_gate();
        test_timeout();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
